regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between NREQ requesters, e.g. ALU writeback, load unit and multiplier.
- Uses a round-robin valid/ready handshake and drives one registered write per cycle.
- wr_addr feeds the 5-to-32 write-select decoder; wr_en gates the decoded enables.
- Writes to register 0 are accepted but never reach the port, and each one is counted.

---
 rtl/regfile_wr_arbiter_if.sv | 39 +++
 rtl/regfile_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_if
// Bundles the signals between the requesters and the register-file write
// port.
//   req_valid/req_ready/req_addr/req_data : per-requester valid/ready write
//                                           requests, packed k-major
//   stall                                 : freezes arbitration
//   wr_en/wr_addr/wr_data/wr_src          : registered write port
//   r0_drop_cnt                           : saturating count of writes to r0
// Modports: slave  = the arbiter's view
//           master = the requester / register-file view
// ---------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int GW   = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               stall;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic [GW-1:0]      wr_src;
    logic [7:0]         r0_drop_cnt;

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, wr_en, wr_addr, wr_data, wr_src, r0_drop_cnt
    );

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, wr_en, wr_addr, wr_data, wr_src, r0_drop_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single register-file write port between NREQ requesters using a
// round-robin valid/ready handshake. One accepted request per cycle becomes a
// registered write one cycle later. Writes to register 0 are accepted but
// suppressed on the port, and counted in a saturating 8-bit counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   rf    : regfile_wr_arbiter_if.slave (requests, stall, write port, r0 count)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32,
    parameter int GW   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_wr_arbiter_if.slave      rf
);

    if (NREQ < 2 || NREQ > 8 || GW != $clog2(NREQ)) begin : g_bad_params
        $error("regfile_wr_arbiter: NREQ must be 2..8 and GW must equal clog2(NREQ)");
    end

    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [GW-1:0]   wr_src_q, wr_src_d;
    logic [7:0]      r0_cnt_q, r0_cnt_d;

    logic            grant_vld;
    logic [GW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    // Round-robin search starting at rr_ptr; the wrap is done by subtraction
    // rather than masking so that non-power-of-two NREQ works.
    always_comb begin
        int k;
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        k         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant     = '0;
        if (!rf.stall) begin
            for (int i = 0; i < NREQ; i++) begin
                k = int'(rr_ptr_q) + i;
                if (k >= NREQ) k = k - NREQ;
                if (!grant_vld && rf.req_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = GW'(k);
                end
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    // Ready is forced low while reset is asserted, even with valid requests.
    assign rf.req_ready = rst_n ? grant : '0;

    assign sel_addr = rf.req_addr[int'(grant_idx)*AW +: AW];
    assign sel_data = rf.req_data[int'(grant_idx)*DW +: DW];

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = grant_vld && (sel_addr != '0);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        r0_cnt_d  = r0_cnt_q;

        if (grant_vld) begin
            rr_ptr_d = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + GW'(1);
        end

        // A register-0 write completes the handshake but leaves the port
        // fields untouched, so the decoder sees the last real write.
        if (wr_en_d) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
            wr_src_d  = grant_idx;
        end

        if (grant_vld && (sel_addr == '0) && (r0_cnt_q != 8'hFF)) begin
            r0_cnt_d = r0_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            r0_cnt_q  <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            r0_cnt_q  <= r0_cnt_d;
        end
    end

    assign rf.wr_en       = wr_en_q;
    assign rf.wr_addr     = wr_addr_q;
    assign rf.wr_data     = wr_data_q;
    assign rf.wr_src      = wr_src_q;
    assign rf.r0_drop_cnt = r0_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter: a 4-requester instance (a) and a
// 3-requester instance (b). Inputs change 1 ns after a rising edge; registered
// outputs are sampled there, combinational ready 1 ns later.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    regfile_wr_arbiter_if #(.NREQ(4), .AW(5), .DW(32), .GW(2)) a_if ();
    regfile_wr_arbiter_if #(.NREQ(3), .AW(5), .DW(32), .GW(2)) b_if ();

    regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(32), .GW(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (a_if)
    );

    regfile_wr_arbiter #(.NREQ(3), .AW(5), .DW(32), .GW(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input logic [4:0] addr, input logic [31:0] data);
        a_if.req_addr[k*5 +: 5]  = addr;
        a_if.req_data[k*32 +: 32] = data;
    endtask

    task automatic set_b(input int k, input logic [4:0] addr, input logic [31:0] data);
        b_if.req_addr[k*5 +: 5]  = addr;
        b_if.req_data[k*32 +: 32] = data;
    endtask

    initial begin
        int rr_a [7];
        int rr_b [6];
        rr_a = '{3, 0, 1, 2, 3, 0, 1};
        rr_b = '{0, 1, 2, 0, 1, 2};

        // ---------------- reset state ----------------
        rst_n          = 1'b0;
        a_if.req_valid = 4'hF;
        a_if.req_addr  = '0;
        a_if.req_data  = '0;
        a_if.stall     = 1'b0;
        b_if.req_valid = '0;
        b_if.req_addr  = '0;
        b_if.req_data  = '0;
        b_if.stall     = 1'b0;
        #2;
        check("rst_ready", 64'(a_if.req_ready), 64'h0);
        check("rst_wr_en", 64'(a_if.wr_en), 64'h0);
        check("rst_wr_addr", 64'(a_if.wr_addr), 64'h0);
        check("rst_wr_data", 64'(a_if.wr_data), 64'h0);
        check("rst_wr_src", 64'(a_if.wr_src), 64'h0);
        check("rst_r0_cnt", 64'(a_if.r0_drop_cnt), 64'h0);
        a_if.req_valid = '0;
        step();
        rst_n = 1'b1;

        // ---------------- single requester ----------------
        a_if.req_valid = 4'b0010;
        set_a(1, 5'd7, 32'hDEADBEEF);
        #1;
        check("single_ready", 64'(a_if.req_ready), 64'b0010);
        step();
        check("single_wr_en", 64'(a_if.wr_en), 64'h1);
        check("single_wr_addr", 64'(a_if.wr_addr), 64'd7);
        check("single_wr_data", 64'(a_if.wr_data), 64'hDEADBEEF);
        check("single_wr_src", 64'(a_if.wr_src), 64'd1);
        a_if.req_valid = '0;
        step();
        check("single_after_en", 64'(a_if.wr_en), 64'h0);
        check("single_hold_addr", 64'(a_if.wr_addr), 64'd7);

        // ---------------- register 0 drops (rr_ptr = 2) ----------------
        a_if.req_valid = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            set_a(2, 5'd0, 32'h0000_0E00 + 32'(j));
            #1;
            check("r0_ready", 64'(a_if.req_ready), 64'b0100);
            step();
            check("r0_wr_en", 64'(a_if.wr_en), 64'h0);
            check("r0_hold_addr", 64'(a_if.wr_addr), 64'd7);
            check("r0_hold_data", 64'(a_if.wr_data), 64'hDEADBEEF);
            check("r0_hold_src", 64'(a_if.wr_src), 64'd1);
            check("r0_cnt", 64'(a_if.r0_drop_cnt), 64'(j + 1));
        end
        set_a(2, 5'd5, 32'h5555_5555);
        step();
        check("r0_after_en", 64'(a_if.wr_en), 64'h1);
        check("r0_after_addr", 64'(a_if.wr_addr), 64'd5);
        check("r0_after_data", 64'(a_if.wr_data), 64'h5555_5555);
        check("r0_after_src", 64'(a_if.wr_src), 64'd2);
        check("r0_after_cnt", 64'(a_if.r0_drop_cnt), 64'd3);

        // ---------------- round robin (rr_ptr = 3) ----------------
        for (int k = 0; k < 4; k++) set_a(k, 5'(10 + k), 32'hA000_0000 + 32'(k));
        a_if.req_valid = 4'hF;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("rr_ready", 64'(a_if.req_ready), 64'(1) << rr_a[i]);
            step();
            check("rr_wr_en", 64'(a_if.wr_en), 64'h1);
            check("rr_wr_src", 64'(a_if.wr_src), 64'(rr_a[i]));
            check("rr_wr_addr", 64'(a_if.wr_addr), 64'(10 + rr_a[i]));
            check("rr_wr_data", 64'(a_if.wr_data), 64'hA000_0000 + 64'(rr_a[i]));
        end

        // ---------------- stall (rr_ptr = 2) ----------------
        a_if.stall = 1'b1;
        #1;
        check("stall_ready_now", 64'(a_if.req_ready), 64'h0);
        check("stall_inflight_en", 64'(a_if.wr_en), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_wr_en", 64'(a_if.wr_en), 64'h0);
            check("stall_ready", 64'(a_if.req_ready), 64'h0);
            check("stall_hold_src", 64'(a_if.wr_src), 64'd1);
        end
        a_if.stall = 1'b0;
        #1;
        check("unstall_ready", 64'(a_if.req_ready), 64'b0100);
        step();
        check("unstall_wr_en", 64'(a_if.wr_en), 64'h1);
        check("unstall_wr_src", 64'(a_if.wr_src), 64'd2);

        // ---------------- reset mid-stream ----------------
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(a_if.wr_en), 64'h0);
        check("mid_rst_wr_addr", 64'(a_if.wr_addr), 64'h0);
        check("mid_rst_wr_data", 64'(a_if.wr_data), 64'h0);
        check("mid_rst_wr_src", 64'(a_if.wr_src), 64'h0);
        check("mid_rst_r0_cnt", 64'(a_if.r0_drop_cnt), 64'h0);
        check("mid_rst_ready", 64'(a_if.req_ready), 64'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(a_if.req_ready), 64'b0001);
        step();
        check("post_rst_wr_src", 64'(a_if.wr_src), 64'd0);
        check("post_rst_wr_addr", 64'(a_if.wr_addr), 64'd10);
        a_if.req_valid = '0;

        // ---------------- r0 counter saturation ----------------
        set_a(0, 5'd0, 32'h1234_5678);
        a_if.req_valid = 4'b0001;
        for (int i = 0; i < 255; i++) step();
        check("sat_cnt_255", 64'(a_if.r0_drop_cnt), 64'd255);
        for (int i = 0; i < 45; i++) step();
        check("sat_cnt_300", 64'(a_if.r0_drop_cnt), 64'd255);
        check("sat_wr_en", 64'(a_if.wr_en), 64'h0);
        a_if.req_valid = '0;

        // ---------------- NREQ = 3 round robin ----------------
        for (int k = 0; k < 3; k++) set_b(k, 5'(k + 1), 32'hB0 + 32'(k));
        b_if.req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("np2_ready", 64'(b_if.req_ready), 64'(1) << rr_b[i]);
            step();
            check("np2_wr_en", 64'(b_if.wr_en), 64'h1);
            check("np2_wr_src", 64'(b_if.wr_src), 64'(rr_b[i]));
            check("np2_wr_data", 64'(b_if.wr_data), 64'hB0 + 64'(rr_b[i]));
            check("np2_src_not3", 64'(b_if.wr_src != 2'd3), 64'h1);
        end
        b_if.req_valid = '0;
        step();
        check("np2_idle_en", 64'(b_if.wr_en), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
